channel_special_dump: RTL and testbench

//  Reader side of the per-channel special register file (CSB, MEMPAGE).
//  On a start command it walks a range of channels via rchanid and captures

---
 rtl/channel_special_dump_pkg.sv | 38 +++
 rtl/channel_special_dump_chan_range_counter.sv | 58 +++++
 rtl/channel_special_dump.sv | 170 +++++++++++++++++
 tb/tb_channel_special_dump.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_special_dump_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : channel_special_dump_pkg                                      |
// | Purpose  : Shared FSM state encoding, header tag and record layout for   |
// |            the per-channel special register dump engine.                 |
// | Contents : state_e      - dump FSM states                                |
// |            HDRTAG_DEFAULT - upper nibble of every record header byte     |
// |            REC_LEN      - bytes per channel record (HDR, CSB, MEMPAGE)   |
// |            rec_idx()    - byte position of a streaming state in a record |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package channel_special_dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_CAPT = 3'd2,
      ST_HDR  = 3'd3,
      ST_CSB  = 3'd4,
      ST_MP   = 3'd5,
      ST_DONE = 3'd6
   } state_e;

   localparam logic [3:0]  HDRTAG_DEFAULT = 4'hC;
   localparam int unsigned REC_LEN        = 3;
   localparam logic [1:0]  REC_LAST_IDX   = 2'(REC_LEN - 1);

   // Position of the byte a streaming state presents within its record.
   function automatic logic [1:0] rec_idx(input state_e s);
      case (s)
         ST_CSB:  return 2'd1;
         ST_MP:   return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/channel_special_dump_chan_range_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : chan_range_counter                                            |
// | Purpose  : Tracks the channel being dumped and how many remain after it. |
// |            The range wraps modulo 2**CHW, so last < first walks through  |
// |            the top channel back to 0.                                    |
// | Ports    : clk, reset      - clock, synchronous active-high reset        |
// |            load            - latch first/last, cur = first               |
// |            advance         - cur = cur + 1, remaining = remaining - 1    |
// |            first_chan/last_chan - range bounds (inclusive)               |
// |            cur             - current channel                             |
// |            is_final        - current channel is the last of the range    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module chan_range_counter #(
   parameter int unsigned CHW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           advance,
   input  logic [CHW-1:0] first_chan,
   input  logic [CHW-1:0] last_chan,
   output logic [CHW-1:0] cur,
   output logic           is_final
);

   logic [CHW-1:0] cur_q, cur_d;
   logic [CHW-1:0] remaining_q, remaining_d;

   // Modular subtraction gives (count - 1) directly, including the wrap case.
   always_comb begin
      cur_d       = cur_q;
      remaining_d = remaining_q;
      if (load) begin
         cur_d       = first_chan;
         remaining_d = last_chan - first_chan;
      end else if (advance) begin
         cur_d       = cur_q + CHW'(1);
         remaining_d = remaining_q - CHW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_q       <= '0;
         remaining_q <= '0;
      end else begin
         cur_q       <= cur_d;
         remaining_q <= remaining_d;
      end
   end

   assign cur      = cur_q;
   assign is_final = (remaining_q == '0);

endmodule
`default_nettype wire

// File: rtl/channel_special_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : channel_special_dump                                          |
// | Purpose  : Reader side of the per-channel special register file. On a    |
// |            start command, walks a channel range via rchanid, captures    |
// |            qcsb/qmempage and streams a 3-byte record per channel:        |
// |            {HDRTAG,chan}, CSB, MEMPAGE. Never writes the register file.  |
// | Ports    : clk, reset          - clock, synchronous active-high reset    |
// |            start, first_chan, last_chan - dump request and range        |
// |            abort               - cancel an in-progress dump              |
// |            rchanid, qcsb, qmempage - register file read port            |
// |            out_data/out_valid/out_ready/out_last - byte stream          |
// |            busy, done          - status                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module channel_special_dump
   import channel_special_dump_pkg::*;
#(
   parameter int unsigned CHW    = 4,
   parameter int unsigned DW     = 8,
   parameter logic [3:0]  HDRTAG = HDRTAG_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [CHW-1:0] first_chan,
   input  logic [CHW-1:0] last_chan,
   input  logic           abort,
   output logic [CHW-1:0] rchanid,
   input  logic [DW-1:0]  qcsb,
   input  logic [DW-1:0]  qmempage,
   output logic [DW-1:0]  out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_last,
   output logic           busy,
   output logic           done
);

   state_e         state_q, state_d;
   logic [DW-1:0]  csb_h_q, csb_h_d;
   logic [DW-1:0]  mp_h_q, mp_h_d;
   logic [CHW-1:0] rchanid_q, rchanid_d;
   logic [DW-1:0]  out_data_q, out_data_d;
   logic           out_valid_q, out_valid_d;
   logic           out_last_q, out_last_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           ctr_load;
   logic           ctr_advance;
   logic [CHW-1:0] cur;
   logic           is_final;
   logic           accept;

   chan_range_counter #(
      .CHW (CHW)
   ) u_range (
      .clk        (clk),
      .reset      (reset),
      .load       (ctr_load),
      .advance    (ctr_advance),
      .first_chan (first_chan),
      .last_chan  (last_chan),
      .cur        (cur),
      .is_final   (is_final)
   );

   assign accept = out_valid_q && out_ready;

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      csb_h_d     = csb_h_q;
      mp_h_d      = mp_h_q;
      ctr_load    = 1'b0;
      ctr_advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ctr_load = 1'b1;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: state_d = ST_CAPT;
         ST_CAPT: begin
            // Snapshot here; later register-file writes do not affect the record.
            csb_h_d = qcsb;
            mp_h_d  = qmempage;
            state_d = ST_HDR;
         end
         ST_HDR: if (accept) state_d = ST_CSB;
         ST_CSB: if (accept) state_d = ST_MP;
         ST_MP: begin
            if (accept) begin
               if (is_final) begin
                  state_d = ST_DONE;
               end else begin
                  ctr_advance = 1'b1;
                  state_d     = ST_ADDR;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Abort overrides everything, including a start seen in IDLE.
      if (abort) begin
         state_d     = ST_IDLE;
         ctr_load    = 1'b0;
         ctr_advance = 1'b0;
      end
   end

   // Registered outputs are derived from the state being entered.
   always_comb begin
      rchanid_d = rchanid_q;
      if (ctr_load) begin
         rchanid_d = first_chan;
      end else if (ctr_advance) begin
         rchanid_d = cur + CHW'(1);
      end

      out_valid_d = (state_d inside {ST_HDR, ST_CSB, ST_MP});
      busy_d      = (state_d inside {ST_ADDR, ST_CAPT, ST_HDR, ST_CSB, ST_MP});
      done_d      = (state_d == ST_DONE);

      case (state_d)
         ST_HDR:  out_data_d = DW'({HDRTAG, cur});
         ST_CSB:  out_data_d = csb_h_d;
         ST_MP:   out_data_d = mp_h_d;
         default: out_data_d = '0;
      endcase

      out_last_d = out_valid_d && (rec_idx(state_d) == REC_LAST_IDX) && is_final;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         csb_h_q     <= '0;
         mp_h_q      <= '0;
         rchanid_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         csb_h_q     <= csb_h_d;
         mp_h_q      <= mp_h_d;
         rchanid_q   <= rchanid_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rchanid   = rchanid_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_special_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_channel_special_dump                                       |
// | Purpose  : Self-checking bench for channel_special_dump. A record-level  |
// |            model expands each accepted range into the expected byte list |
// |            and a negedge process checks every cycle against it.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_channel_special_dump;

   logic       clk = 1'b0;
   logic       reset, start, abort, out_ready;
   logic [3:0] first_chan, last_chan, rchanid;
   logic [7:0] qcsb, qmempage, out_data;
   logic       out_valid, out_last, busy, done;

   channel_special_dump dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .first_chan (first_chan),
      .last_chan  (last_chan),
      .abort      (abort),
      .rchanid    (rchanid),
      .qcsb       (qcsb),
      .qmempage   (qmempage),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register file: one-cycle read latency from rchanid.
   logic [7:0] csb_mem [16];
   logic [7:0] mp_mem  [16];
   bit         scribble_en = 1'b0;
   always @(posedge clk) begin
      qcsb     <= csb_mem[rchanid];
      qmempage <= mp_mem[rchanid];
      // Rewrite the CSB of the channel currently streaming (already captured).
      if (scribble_en && out_valid) csb_mem[rchanid] <= 8'h55;
   end

   // Ready generator: 0 = always, 1 = random, 2 = one cycle in three.
   int ready_mode = 0;
   int ready_phase = 0;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       out_ready = 1'($urandom_range(0, 1));
         2:       out_ready = (ready_phase == 2);
         default: out_ready = 1'b1;
      endcase
      ready_phase = (ready_phase + 1) % 3;
   end

   // Record-level model.
   logic [7:0] exp_q[$];
   logic [7:0] got[$];
   bit         m_active = 1'b0;
   bit         m_done   = 1'b0;
   bit         lat_armed = 1'b0;
   int         lat_cnt = 0;

   always @(posedge clk) begin
      if (reset || abort) begin
         m_active  = 1'b0;
         m_done    = 1'b0;
         lat_armed = 1'b0;
         exp_q.delete();
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (!m_active) begin
         if (start) begin
            int n;
            n = ((int'(last_chan) - int'(first_chan)) & 15) + 1;
            for (int k = 0; k < n; k++) begin
               int c;
               c = (int'(first_chan) + k) & 15;
               exp_q.push_back({4'hC, 4'(c)});
               exp_q.push_back(csb_mem[c]);
               exp_q.push_back(mp_mem[c]);
            end
            m_active  = 1'b1;
            lat_armed = 1'b1;
            lat_cnt   = 0;
         end
      end else if (out_valid && out_ready && exp_q.size() > 0) begin
         got.push_back(out_data);
         void'(exp_q.pop_front());
         if (exp_q.size() == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
   end

   // Per-cycle compare.
   bit         cmp_en = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   always @(negedge clk) begin
      if (cmp_en) begin
         check("done", 32'(done), 32'(m_done));
         check("busy", 32'(busy), 32'(m_active));
         if (!m_active) check("valid_idle", 32'(out_valid), 32'd0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               check("data", 32'(out_data), 32'(exp_q[0]));
               check("last", 32'(out_last), 32'(exp_q.size() == 1));
            end
         end else begin
            check("last_novalid", 32'(out_last), 32'd0);
         end
         if (prev_stall && m_active)
            check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
         // Start cycle counts as 1: valid must appear in the 4th cycle.
         if (lat_armed) begin
            lat_cnt++;
            if (lat_cnt == 3) begin
               check("first_valid_latency", 32'(out_valid), 32'd1);
               lat_armed = 1'b0;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic wait_done(input int max, output int cycles);
      cycles = 0;
      forever begin
         @(negedge clk);
         cycles++;
         if (done) return;
         if (cycles >= max) begin
            check("done_timeout", 32'(cycles), 32'(max + 1));
            return;
         end
      end
   endtask

   task automatic wait_byte(input logic [7:0] b, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (out_valid && out_data == b) return;
      end
      check("byte_timeout", 32'(max), 32'd0);
   endtask

   task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int mode,
                           output int cycles);
      ready_mode = mode;
      got.delete();
      @(posedge clk); #1;
      first_chan = f; last_chan = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(2000, cycles);
   endtask

   task automatic fill_default();
      for (int c = 0; c < 16; c++) begin
         csb_mem[c] = 8'(c);
         mp_mem[c]  = 8'(c << 4);
      end
   endtask

   initial begin
      int cyc;
      int n;
      logic [3:0] f, l;
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      first_chan = '0; last_chan = '0;
      fill_default();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rchanid", 32'(rchanid), 32'd0);
      check("rst_data",    32'(out_data), 32'd0);
      check("rst_valid",   32'(out_valid), 32'd0);
      check("rst_last",    32'(out_last), 32'd0);
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_done",    32'(done), 32'd0);
      reset  = 1'b0;
      cmp_en = 1'b1;

      // 1: full 0..15 dump, ready always high: 16 x 5 cycles then DONE.
      run_dump(4'd0, 4'd15, 0, cyc);
      check("t1_cycles", 32'(cyc), 32'd81);
      check("t1_count",  32'(got.size()), 32'd48);
      if (got.size() == 48) begin
         check("t1_b0",  32'(got[0]),  32'hC0);
         check("t1_b1",  32'(got[1]),  32'h00);
         check("t1_b3",  32'(got[3]),  32'hC1);
         check("t1_b5",  32'(got[5]),  32'h10);
         check("t1_b47", 32'(got[47]), 32'hF0);
      end

      // 2: wrap 14..1, random ready.
      run_dump(4'd14, 4'd1, 1, cyc);
      check("t2_count", 32'(got.size()), 32'd12);
      if (got.size() == 12) begin
         check("t2_h0", 32'(got[0]),  32'hCE);
         check("t2_h1", 32'(got[3]),  32'hCF);
         check("t2_h2", 32'(got[6]),  32'hC0);
         check("t2_h3", 32'(got[9]),  32'hC1);
         check("t2_mp", 32'(got[11]), 32'h10);
      end

      // 3: single channel with ready one cycle in three.
      run_dump(4'd5, 4'd5, 2, cyc);
      check("t3_count", 32'(got.size()), 32'd3);
      if (got.size() == 3)
         check("t3_bytes", {8'd0, got[0], got[1], got[2]}, 32'h00C5_0550);

      // 4: abort during CSB byte of channel 3.
      ready_mode = 0;
      @(posedge clk); #1;
      first_chan = 4'd0; last_chan = 4'd15; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_byte(8'h03, 100);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("t4_valid", 32'(out_valid), 32'd0);
      check("t4_busy",  32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      run_dump(4'd2, 4'd4, 1, cyc);
      check("t4_recover_count", 32'(got.size()), 32'd9);

      // 5: start while busy ignored; CSB rewritten after capture.
      csb_mem[7] = 8'hAA;
      scribble_en = 1'b1;
      fork
         run_dump(4'd6, 4'd8, 1, cyc);
         begin
            repeat (9) @(posedge clk);
            #1; first_chan = 4'd0; last_chan = 4'd0; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
         end
      join
      scribble_en = 1'b0;
      check("t5_count", 32'(got.size()), 32'd9);
      if (got.size() == 9) check("t5_csb7", 32'(got[4]), 32'hAA);
      repeat (3) @(negedge clk);
      check("t5_no_requeue", 32'(busy), 32'd0);
      fill_default();

      // 6: reset in mid-record.
      ready_mode = 1;
      @(posedge clk); #1;
      first_chan = 4'd0; last_chan = 4'd15; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_byte(8'hC2, 200);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6_rchanid", 32'(rchanid), 32'd0);
      check("t6_data",    32'(out_data), 32'd0);
      check("t6_valid",   32'(out_valid), 32'd0);
      check("t6_busy",    32'(busy), 32'd0);
      reset = 1'b0;
      run_dump(4'd9, 4'd9, 0, cyc);
      check("t6_recover", 32'(got.size()), 32'd3);

      // Randomized ranges and register contents.
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < 16; c++) begin
            csb_mem[c] = 8'($urandom);
            mp_mem[c]  = 8'($urandom);
         end
         f = 4'($urandom);
         l = 4'($urandom);
         n = ((int'(l) - int'(f)) & 15) + 1;
         scribble_en = 1'($urandom_range(0, 1));
         run_dump(f, l, int'($urandom_range(0, 2)), cyc);
         scribble_en = 1'b0;
         check("rand_count", 32'(got.size()), 32'(3 * n));
      end

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
